// File: rtl/fifo_wr_arbiter_pkg.sv
// ==========================================================================
// fifo_wr_arbiter_pkg : shared state type and width helpers | Rev 1.0
// ==========================================================================
`default_nettype none

package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int GRANT_W         = clog2(DEFAULT_NUM_REQ);

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ==========================================================================
// fifo_wr_arbiter_rr_pick : combinational round-robin selector | Rev 1.0
// ==========================================================================
`default_nettype none

module fifo_wr_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_last,
  output logic         o_found,
  output logic [W-1:0] o_index
);

  function automatic logic [W-1:0] wrap(input int v);
    return W'(v % N);
  endfunction

  // Walk from farthest to nearest so the nearest valid slot after i_last wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_valid[wrap(int'(i_last) + k)]) begin
        o_found = 1'b1;
        o_index = wrap(int'(i_last) + k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ==========================================================================
// fifo_wr_arbiter : round-robin burst arbiter for one shared fifo write port
// Optional per-requester beat counters: FIFO_ARB_STATS_EN | Rev 1.0
// ==========================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int SEL_W    = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  output logic [SEL_W-1:0]         grant_id,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    beat_count
`endif
);

  localparam int BC_W = clog2(MAX_BURST) + 1;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [BC_W-1:0]   r_beat_cnt;
  logic              r_wr_en;
  logic [WIDTH-1:0]  r_din;
  logic [SEL_W-1:0]  r_grant_id;

  logic              w_pick_found;
  logic [SEL_W-1:0]  w_pick_idx;
  logic              w_sel_valid;
  logic              w_xfer;
  logic              w_last_beat;

  // r_grant_id doubles as last_grant: it only changes when a new grant is made.
  fifo_wr_arbiter_rr_pick #(
    .N (NUM_REQ),
    .W (SEL_W)
  ) u_rr_pick (
    .i_valid (req_valid),
    .i_last  (r_grant_id),
    .o_found (w_pick_found),
    .o_index (w_pick_idx)
  );

  assign w_sel_valid = req_valid[r_grant_id];
  assign w_xfer      = (r_state == GRANT) && w_sel_valid && !fifo_full;
  assign w_last_beat = (r_beat_cnt == BC_W'(MAX_BURST - 1));

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_found) w_state_nxt = GRANT;
      end
      GRANT: begin
        if (w_xfer) req_ready[r_grant_id] = 1'b1;
        if (!w_sel_valid || (w_xfer && w_last_beat)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
      r_grant_id <= SEL_W'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_din      <= req_data[int'(r_grant_id)*WIDTH +: WIDTH];
        r_beat_cnt <= r_beat_cnt + BC_W'(1);
      end
      if ((r_state == IDLE) && w_pick_found) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end
    end
  end

  assign fifo_wr_en = r_wr_en;
  assign fifo_din   = r_din;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state == GRANT);

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [15:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_xfer && (r_grant_id == SEL_W'(gi)) && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign beat_count[gi*16 +: 16] = r_cnt;
  end
`endif

endmodule

`default_nettype wire
